// File: rtl/i2c_host_writer.sv
// i2c_host_writer: write-only I2C initiator (START, addr+W, 0..15 data bytes with ACK check, STOP).
// Define I2C_CLK_STRETCH_EN to hold the high phases while a target stretches SCL.
module i2c_host_writer #(
    parameter int CLK_DIV = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic [3:0] cmd_len,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       nack,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe
);
    typedef enum logic [2:0] {IDLE, START, BIT, LOAD, STOP} state_t;
    localparam logic [7:0] QMAX = 8'(CLK_DIV);

    state_t     state_q, state_d;
    logic [7:0] qcnt_q, qcnt_d, sh_q, sh_d;
    logic [1:0] phase_q, phase_d, sda_s_q, sda_s_d;
    logic [3:0] bit_q, bit_d, rem_q, rem_d;
    logic       nack_q, nack_d, done_q, done_d, hold, tick;

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] scl_s_q, scl_s_d;
    assign scl_s_d = {scl_s_q[0], scl_in};
    assign hold = ~scl_s_q[1] & ((state_q == BIT & phase_q[1]) | (state_q == STOP & phase_q == 2'd1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) scl_s_q <= 2'b11;
        else scl_s_q <= scl_s_d;
    end
`else
    logic unused_scl;
    assign unused_scl = scl_in;
    assign hold = 1'b0;
`endif

    assign tick = (qcnt_q == QMAX) & ~hold;

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        nack_d  = nack_q;
        done_d  = 1'b0;
        sda_s_d = {sda_s_q[0], sda_in};
        if (state_q inside {START, BIT, STOP} && !hold) qcnt_d = tick ? 8'd0 : qcnt_q + 8'd1;
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d = START;
                qcnt_d  = 8'd0;
                phase_d = 2'd0;
                sh_d    = {cmd_addr, 1'b0};
                rem_d   = cmd_len;
                nack_d  = 1'b0;
            end
            START: if (tick) begin
                phase_d = phase_q[0] ? 2'd0 : 2'd1;
                bit_d   = 4'd0;
                state_d = phase_q[0] ? BIT : START;
            end
            BIT: if (tick) begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3 && bit_q != 4'd8) begin
                    bit_d = bit_q + 4'd1;
                    sh_d  = sh_q << 1;
                end else if (phase_q == 2'd3) begin
                    nack_d  = nack_q | sda_s_q[1];
                    state_d = (!sda_s_q[1] && rem_q != 4'd0) ? LOAD : STOP;
                end
            end
            // The capture cycle doubles as the first cycle of the next bit's q0
            LOAD: if (tx_valid) begin
                state_d = BIT;
                sh_d    = tx_data;
                rem_d   = rem_q - {3'b000, |rem_q};
                bit_d   = 4'd0;
                phase_d = 2'd0;
                qcnt_d  = 8'd1;
            end
            STOP: if (tick) begin
                phase_d = phase_q == 2'd2 ? 2'd0 : phase_q + 2'd1;
                done_d  = phase_q == 2'd2;
                state_d = phase_q == 2'd2 ? IDLE : STOP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            qcnt_q  <= 8'd0;
            phase_q <= 2'd0;
            bit_q   <= 4'd0;
            sh_q    <= 8'd0;
            rem_q   <= 4'd0;
            nack_q  <= 1'b0;
            done_q  <= 1'b0;
            sda_s_q <= 2'b11;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            nack_q  <= nack_d;
            done_q  <= done_d;
            sda_s_q <= sda_s_d;
        end
    end

    assign cmd_ready = state_q == IDLE;
    assign busy      = ~cmd_ready;
    assign tx_ready  = state_q == LOAD;
    assign done      = done_q;
    assign nack      = nack_q;
    assign scl_oe    = (state_q == START & phase_q == 2'd1) | (state_q == BIT & ~phase_q[1]) |
                       tx_ready | (state_q == STOP & phase_q == 2'd0);
    assign sda_oe    = (state_q == START) | (state_q == BIT & bit_q != 4'd8 & ~sh_q[7]) |
                       (state_q == STOP & ~phase_q[1]);
endmodule

// File: tb/tb_i2c_host_writer.sv
// tb_i2c_host_writer: randomized self-checking bench with a bus-level responder and timing model.
module tb_i2c_host_writer;
    localparam int CLK_DIV = 1;
    localparam int QC = CLK_DIV + 1;
`ifdef I2C_CLK_STRETCH_EN
    localparam int SX = 2;
    localparam int SF = 20;
`else
    localparam int SX = 0;
    localparam int SF = 0;
`endif

    logic       clk = 1'b0, rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, tx_valid = 1'b0, tx_ready;
    logic [6:0] cmd_addr = 7'd0;
    logic [3:0] cmd_len = 4'd0;
    logic [7:0] tx_data = 8'd0;
    logic       busy, done, nack, scl_in, sda_in, scl_oe, sda_oe;
    logic       force_scl = 1'b0, ack_pull = 1'b0;
    int         cyc = 0, n_chk = 0, n_fail = 0;
    logic [7:0] data [16];

    assign scl_in = ~scl_oe & ~force_scl;
    assign sda_in = ~sda_oe & ~ack_pull;

    i2c_host_writer #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done), .nack(nack),
        .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Responder: decodes bytes on SCL rising edges as driven by the controller, ACKs unless told otherwise
    logic       pscl = 1'b1, psda = 1'b1;
    int         rbits = 0, nack_byte = -1;
    logic [7:0] rsh = 8'd0;
    logic [7:0] rx_q [$];

    always @(negedge clk) begin
        logic s, d;
        s = ~scl_oe;
        d = ~sda_oe & ~ack_pull;
        if (pscl && s && psda && !d) rbits = 0;
        else if (!pscl && s) begin
            if (rbits < 8) begin
                rsh = {rsh[6:0], d};
                rbits++;
                if (rbits == 8) rx_q.push_back(rsh);
            end else rbits = 0;
        end else if (pscl && !s) ack_pull = rbits == 8 && (int'(rx_q.size()) - 1 != nack_byte);
        pscl = s;
        psda = ~sda_oe & ~ack_pull;
    end

    task automatic run(input logic [6:0] addr, input int len, input int nb, input int stall_byte,
                       input int stall, input int force_bit, input bit do_rst);
        int n, idx, sc, tr, bad, falls, fcnt, rw, nbytes, sx, exp_done;
        bit hs, pso, got_done, seen;
        idx = 0; sc = 0; tr = 0; bad = 0; falls = 0; fcnt = 0; rw = 0;
        hs = 0; pso = 0; got_done = 0;
        nbytes   = (nb >= 0 && nb <= len) ? nb + 1 : len + 1;
        sx       = (stall_byte < nbytes - 1) ? stall : 0;
        exp_done = 1 + (5 + 36 * nbytes) * QC + sx + SX * (9 * nbytes + 1) + (force_bit >= 0 ? SF : 0);
        rx_q.delete();
        nack_byte = nb;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = 4'(len);
        n = cyc;
        exp_done += n;
        for (int t = 0; t < 6000; t++) begin
            @(negedge clk);
            if (hs) idx++;
            if (done) begin
                cmd_valid = 1'b0;
                tx_valid  = 1'b0;
                got_done  = 1'b1;
                break;
            end
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_addr  = 7'($urandom);
            cmd_len   = 4'($urandom);
            if (cyc == n + 1) begin
                chk("start_sda", sda_oe, 1);
                chk("start_scl", scl_oe, 0);
                chk("busy", busy, 1);
                chk("nack_clr", nack, 0);
            end
            if (tx_ready) tr++;
            if (tx_ready && idx == stall_byte && sc < stall) begin
                sc++;
                tx_valid = 1'b0;
                bad += int'(!scl_oe);
            end else tx_valid = idx < len;
            tx_data = data[idx & 15];
            hs = tx_valid && tx_ready;
            if (fcnt > 0) begin
                fcnt--;
                if (fcnt == 0) force_scl = 1'b0;
            end else if (pso && !scl_oe) begin
                falls++;
                if (falls == force_bit + 1) begin
                    force_scl = 1'b1;
                    fcnt = 20;
                end
            end
            pso = scl_oe;
            if (do_rst && rx_q.size() == 1 && rbits == 3) rw++;
            if (do_rst && rw == 6 + SX) break;
        end
        if (do_rst) begin
            chk("rst_reached", rw, 6 + SX);
            cmd_valid = 1'b0;
            tx_valid  = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            chk("rst_scl", scl_oe, 0);
            chk("rst_sda", sda_oe, 0);
            chk("rst_ready", cmd_ready, 1);
            chk("rst_busy", busy, 0);
            rst = 1'b0;
            seen = 0;
            repeat (40) begin
                @(negedge clk);
                seen |= done;
            end
            chk("rst_no_done", seen, 0);
            return;
        end
        chk("done_seen", got_done, 1);
        chk("done_cyc", cyc, exp_done);
        chk("nack", nack, (nb >= 0 && nb <= len) ? 1 : 0);
        chk("busy_at_done", busy, 0);
        chk("load_cycles", tr, nbytes - 1 + sx);
        chk("stall_scl_low", bad, 0);
        chk("rx_count", rx_q.size(), nbytes);
        for (int i = 0; i < rx_q.size() && i < nbytes; i++)
            chk($sformatf("rx%0d", i), rx_q[i], i == 0 ? {addr, 1'b0} : data[i - 1]);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("ready_after", cmd_ready, 1);
        chk("nack_sticky", nack, (nb >= 0 && nb <= len) ? 1 : 0);
    endtask

    task automatic fill();
        foreach (data[i]) data[i] = 8'($urandom);
    endtask

    initial begin
        int len, nb, sb, st, fb;
        repeat (3) @(negedge clk);
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_nack", nack, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        fill();
        data[0] = 8'hA5;
        data[1] = 8'h3C;
        run(7'h2A, 2, -1, 99, 0, -1, 0);
        run(7'h10, 2, 0, 99, 0, -1, 0);
        run(7'h2A, 0, -1, 99, 0, -1, 0);
        fill();
        run(7'h33, 3, -1, 1, 10, -1, 0);
        run(7'h2A, 1, -1, 99, 0, 2, 0);
        fill();
        run(7'h51, 4, 2, 99, 0, -1, 0);
        for (int r = 0; r < 12; r++) begin
            fill();
            len = $urandom_range(0, 15);
            nb  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len)) : -1;
            sb  = (len > 0) ? int'($urandom_range(0, len - 1)) : 0;
            st  = $urandom_range(0, 12);
            fb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
            run(7'($urandom), len, nb, sb, st, fb, 0);
        end
        fill();
        run(7'h2A, 2, -1, 99, 0, -1, 1);
        fill();
        run(7'h2A, 2, -1, 99, 0, -1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_host_writer.md
# i2c_host_writer

Write-only I2C controller (initiator) for driving the canvas I2C responder from the host/bench side, or for pushing bytes out to external I2C peripherals.
- Accepts one command: 7-bit address plus 0–15 data bytes, streamed in over a valid/ready byte port.
- Generates START, address+W, data bytes, ACK sampling and STOP on open-drain `scl_oe`/`sda_oe` outputs. `oe=1` pulls the line low; `oe=0` releases it.
- Reports completion and NACK status.

## Interface
- `CLK_DIV`, default 63: quarter-bit length is CLK_DIV+1 clk cycles. SCL period is 4·(CLK_DIV+1). Legal range 1..255.
- `clk` in 1: single clock; every flop is in this domain.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE. Accept happens when `cmd_valid & cmd_ready`.
- `cmd_addr` in 7: target address; R/W bit is always 0.
- `cmd_len` in 4: data byte count, 0..15. A value of 0 gives an address-only probe.
- `tx_data` in 8: next data byte.
- `tx_valid` in 1 / `tx_ready` out 1: byte handshake.
- `busy` out 1: high from accept through the last STOP quarter.
- `done` out 1: one-cycle pulse at end of a transaction.
- `nack` out 1: sticky; cleared on the next command accept.
- `scl_in`, `sda_in` in 1 each: pad readback, double-flop synchronised internally.
- `scl_oe`, `sda_oe` out 1 each: open-drain pull-down enables.

## Operation
- **Reset values:** `scl_oe=0`, `sda_oe=0`, `cmd_ready=1`, `tx_ready=0`, `busy=0`, `done=0`, `nack=0`, state IDLE.
- **Accept:** latch addr/len and clear `nack`. Load the shift register with {addr,0}. Go to START.
- **Quarter counter:** counts 0..CLK_DIV. Phases advance on wrap.
- **START** (2 quarters): q0 `sda_oe=1`, `scl_oe=0`; q1 `sda_oe=1`, `scl_oe=1`.
- **BIT** (4 quarters per bit, MSB first): q0–q1 `scl_oe=1`, `sda_oe=~bit`, with SDA changing only at q0 start; q2–q3 `scl_oe=0`.
- **ACK bit:** same 4 quarters with `sda_oe=0`. `sda_in` (synchronised) is sampled on the last cycle of q3. A value of 0 is ACK; 1 is NACK.
- **After ACK:**
  - NACK: set `nack=1`, discard remaining bytes, go to STOP.
  - ACK with bytes remaining: go to LOAD.
  - ACK with no bytes remaining: go to STOP.
- **LOAD:** `tx_ready=1` and `scl_oe=1`, `sda_oe` unchanged. The byte is captured on `tx_valid & tx_ready`, then BIT starts at q0 on the next cycle. LOAD may last indefinitely, which holds SCL low; this is legal for the controller.
- **STOP** (3 quarters): q0 `scl_oe=1`, `sda_oe=1`; q1 `scl_oe=0`, `sda_oe=1`; q2 both 0.
- **End of STOP:** on the cycle after the last STOP quarter, `done=1`, `busy=0`, `cmd_ready=1`.
- **Ignored inputs:** `cmd_valid` while busy and `tx_valid` outside LOAD are ignored.
- **Counters:** the remaining-byte counter is 4-bit, decrements on each LOAD capture, and never wraps below 0.
- **Reset mid-transaction:** lines are released immediately and no STOP is generated. The bench must tolerate a truncated frame.

## Timing
- `sda_oe` rises on cycle N+1 after accept cycle N.
- Stall-free duration is (2 + 36·(len+1) + 3) quarters. `done` fires at N+1+that·(CLK_DIV+1).
- **LOAD overhead:** each LOAD costs ≥1 cycle plus any time `tx_valid` is low.
  - LOAD entry follows ACK q3. The first cycle of LOAD already has `tx_ready=1`.
  - Durations in this section and the test plan count a zero-wait LOAD as 0 extra cycles. The capture cycle is absorbed as BIT q0's first cycle.
- **NACK timing:** `nack` is valid from the cycle after the sampling cycle, no later than the `done` pulse.

## Configuration
- **`I2C_CLK_STRETCH_EN` defined:**
  - In BIT/ACK q2 and q3 and STOP q1, the quarter counter holds while synchronised `scl_in==0`.
  - Target clock stretching therefore extends the high phase by the stretch length plus 2 synchroniser cycles.
- **Not defined:** `scl_in` is unused and timing is purely counter-based.

## Test plan
- **Basic write:** CLK_DIV=1, addr 0x2A, len 2, bytes 0xA5/0x3C presented immediately, responder ACKs all → SDA bytes decode 0x54, 0xA5, 0x3C. Total 113 quarters: `done` at N+227, `nack=0`.
- **Address NACK:** addr 0x10 NACKed → `tx_ready` never high, STOP follows, `nack=1`, `done` at N+1+41·2.
- **Probe:** len 0, ACK → START, 0x54, ACK, STOP only, `done` at N+83.
- **Byte stall:** `tx_valid` held low 10 cycles in LOAD → `scl_oe=1` throughout, total extended by exactly 10 cycles, data intact.
- **Stretch:** with I2C_CLK_STRETCH_EN, `scl_in` forced low 20 cycles during an address bit q2 → that bit extended by 22 cycles. Without the macro, no extension.
- **Reset mid-byte:** assert `rst` during the 4th data bit → next cycle `scl_oe=sda_oe=0`, `cmd_ready=1`, `busy=0`, no `done` pulse.
